// File: rtl/zeroheti_pkg.sv
// System address map shared by the ZeroHeTi interconnect.
// Rule order is the target index: dbg, imem, dmem, clic, ext.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } rule_t;

  localparam int unsigned NumRules = 5;

  typedef rule_t [NumRules-1:0] addr_map_t;

  // 0x0000_A000..0x0000_FFFF is intentionally left unmapped.
  localparam addr_map_t AddrMap = {
    rule_t'{base: 32'h0001_0000, last: 32'hFFFF_FFFF},  // ext
    rule_t'{base: 32'h0000_9000, last: 32'h0000_A000},  // clic
    rule_t'{base: 32'h0000_5000, last: 32'h0000_9000},  // dmem
    rule_t'{base: 32'h0000_1000, last: 32'h0000_5000},  // imem
    rule_t'{base: 32'h0000_0000, last: 32'h0000_1000}   // dbg
  };

endpackage

// File: rtl/zeroheti_bus_demux.sv
// One-initiator to five-target bus demultiplexer with an internal error responder.
// Outstanding requests are restricted to a single target so responses stay in order.
module zeroheti_bus_demux #(
  parameter zeroheti_pkg::addr_map_t AddrMap        = zeroheti_pkg::AddrMap,
  parameter int unsigned             MaxOutstanding = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic [4:0]       tgt_req_o,
  input  logic [4:0]       tgt_gnt_i,
  output logic [31:0]      tgt_addr_o,
  output logic             tgt_we_o,
  output logic [3:0]       tgt_be_o,
  output logic [31:0]      tgt_wdata_o,
  input  logic [4:0]       tgt_rvalid_i,
  input  logic [4:0][31:0] tgt_rdata_i,
  input  logic [4:0]       tgt_err_i
);

  localparam int unsigned NumTgt = zeroheti_pkg::NumRules;
  localparam logic [2:0]  ExtTgt = 3'd4;
  localparam logic [2:0]  ErrTgt = 3'd5;
  localparam logic [2:0]  MaxCnt = 3'(MaxOutstanding);

  logic [2:0]  r_cnt;
  logic [2:0]  r_cur_tgt;
  logic [2:0]  w_cnt_next;
  logic [2:0]  w_cur_next;
  logic [4:0]  w_hit;
  logic [2:0]  w_dec;
  logic        w_mapped;
  logic        w_rsp;
  logic [31:0] w_rsp_data;
  logic        w_rsp_err;
  logic        w_adm;
  logic        w_gnt;
  logic [4:0]  w_tgt_req;

  assign tgt_addr_o  = addr_i;
  assign tgt_we_o    = we_i;
  assign tgt_be_o    = be_i;
  assign tgt_wdata_o = wdata_i;

  // Rule ends are exclusive, so the ext rule needs an explicit hit on the top address.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NumTgt; k++) begin
      w_hit[k] = (addr_i >= AddrMap[k].base) && (addr_i < AddrMap[k].last);
    end
    w_hit[ExtTgt] = w_hit[ExtTgt] | (addr_i == 32'hFFFF_FFFF);
  end

  // Lowest-numbered matching rule wins.
  always_comb begin
    w_dec = ErrTgt;
    for (int k = NumTgt - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_dec = 3'(k);
      end
    end
  end

  assign w_mapped = (w_dec != ErrTgt);

  // The error responder answers one queued unmapped request every cycle.
  always_comb begin
    w_rsp      = 1'b0;
    w_rsp_data = '0;
    w_rsp_err  = 1'b0;
    if (r_cnt != 3'd0) begin
      if (r_cur_tgt == ErrTgt) begin
        w_rsp     = 1'b1;
        w_rsp_err = 1'b1;
      end else if (r_cur_tgt < ErrTgt) begin
        w_rsp = tgt_rvalid_i[r_cur_tgt];
        if (w_rsp) begin
          w_rsp_data = tgt_rdata_i[r_cur_tgt];
          w_rsp_err  = tgt_err_i[r_cur_tgt];
        end
      end
    end
  end

  assign rvalid_o = w_rsp;
  assign rdata_o  = w_rsp_data;
  assign err_o    = w_rsp_err;

  // A target switch may proceed in the cycle the last outstanding response drains.
  assign w_adm = req_i && !rst_i && (r_cnt < MaxCnt) &&
                 ((r_cnt == 3'd0) || ((r_cnt == 3'd1) && w_rsp) || (r_cur_tgt == w_dec));

  always_comb begin
    w_tgt_req = '0;
    w_gnt     = 1'b0;
    if (w_adm) begin
      if (w_mapped) begin
        w_tgt_req[w_dec] = 1'b1;
        w_gnt            = tgt_gnt_i[w_dec];
      end else begin
        w_gnt = 1'b1;
      end
    end
  end

  assign tgt_req_o = w_tgt_req;
  assign gnt_o     = w_gnt;

  always_comb begin
    w_cnt_next = r_cnt;
    w_cur_next = r_cur_tgt;
    if (w_gnt) begin
      w_cur_next = w_dec;
    end
    if (w_gnt && !w_rsp) begin
      w_cnt_next = r_cnt + 3'd1;
    end else if (!w_gnt && w_rsp) begin
      w_cnt_next = r_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_cur_tgt <= '0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_cur_tgt <= w_cur_next;
    end
  end

endmodule

// File: tb/tb_zeroheti_bus_demux.sv
// Scoreboard bench for zeroheti_bus_demux: directed corner cases followed by random traffic
// checked against a queue-based model of the address map and outstanding-request rules.
module tb_zeroheti_bus_demux;

  localparam int unsigned Max = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic             gnt_o;
  logic [31:0]      addr_i;
  logic             we_i;
  logic [3:0]       be_i;
  logic [31:0]      wdata_i;
  logic             rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic [4:0]       tgt_req_o;
  logic [4:0]       tgt_gnt_i;
  logic [31:0]      tgt_addr_o;
  logic             tgt_we_o;
  logic [3:0]       tgt_be_o;
  logic [31:0]      tgt_wdata_o;
  logic [4:0]       tgt_rvalid_i;
  logic [4:0][31:0] tgt_rdata_i;
  logic [4:0]       tgt_err_i;

  zeroheti_bus_demux #(
    .MaxOutstanding(Max)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .tgt_req_o   (tgt_req_o),
    .tgt_gnt_i   (tgt_gnt_i),
    .tgt_addr_o  (tgt_addr_o),
    .tgt_we_o    (tgt_we_o),
    .tgt_be_o    (tgt_be_o),
    .tgt_wdata_o (tgt_wdata_o),
    .tgt_rvalid_i(tgt_rvalid_i),
    .tgt_rdata_i (tgt_rdata_i),
    .tgt_err_i   (tgt_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int outs[$];   // model: target index of every accepted, unanswered request
  int exp_q[$];  // scoreboard: target expected to supply each future response
  bit drain    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0..4 = dbg, imem, dmem, clic, ext; 5 = unmapped.
  function automatic int ref_decode(input logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if (a < 32'h0000_5000) return 1;
    if (a < 32'h0000_9000) return 2;
    if (a < 32'h0000_A000) return 3;
    if (a >= 32'h0001_0000) return 4;
    return 5;
  endfunction

  // Reference model: predicts grant/request/response-valid each cycle.
  int         m_dec;
  int         m_n;
  bit         m_rsp;
  bit         m_adm;
  bit         m_gnt;
  logic [4:0] m_req;

  always @(negedge clk_i) begin
    if (rst_i) begin
      outs.delete();
      exp_q.delete();
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_tgt_req", 32'(tgt_req_o), 0);
      chk("rst_rvalid", 32'(rvalid_o), 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_err", 32'(err_o), 0);
    end else begin
      m_dec = ref_decode(addr_i);
      m_n   = outs.size();
      m_rsp = 1'b0;
      if (m_n > 0) begin
        if (outs[0] == 5) m_rsp = 1'b1;
        else              m_rsp = tgt_rvalid_i[outs[0]];
      end
      m_adm = req_i && (m_n < Max) &&
              ((m_n == 0) || ((m_n == 1) && m_rsp) || (outs[m_n-1] == m_dec));
      m_gnt = 1'b0;
      m_req = '0;
      if (m_adm) begin
        if (m_dec == 5) begin
          m_gnt = 1'b1;
        end else begin
          m_req[m_dec] = 1'b1;
          m_gnt        = tgt_gnt_i[m_dec];
        end
      end
      chk("gnt", 32'(gnt_o), 32'(m_gnt));
      chk("tgt_req", 32'(tgt_req_o), 32'(m_req));
      chk("rvalid", 32'(rvalid_o), 32'(m_rsp));
      chk("tgt_addr", tgt_addr_o, addr_i);
      chk("tgt_wdata", tgt_wdata_o, wdata_i);
      chk("tgt_we_be", {27'b0, tgt_we_o, tgt_be_o}, {27'b0, we_i, be_i});
      if (m_rsp) void'(outs.pop_front());
      if (m_gnt) begin
        outs.push_back(m_dec);
        exp_q.push_back(m_dec);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  int mon_t;
  always @(negedge clk_i) begin
    #1;
    if (!rst_i) begin
      if (rvalid_o) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rvalid_o), 0);
        end else begin
          mon_t = exp_q.pop_front();
          if (mon_t == 5) begin
            chk("errrsp_rdata", rdata_o, 0);
            chk("errrsp_err", 32'(err_o), 1);
          end else begin
            chk("rsp_rdata", rdata_o, tgt_rdata_i[mon_t]);
            chk("rsp_err", 32'(err_o), 32'(tgt_err_i[mon_t]));
          end
        end
      end else begin
        chk("idle_rdata", rdata_o, 0);
        chk("idle_err", 32'(err_o), 0);
      end
    end
  end

  task automatic drive(input bit r, input logic [31:0] a, input logic [4:0] g,
                       input logic [4:0] rv);
    @(posedge clk_i);
    #1;
    req_i        = r;
    addr_i       = a;
    we_i         = 1'b0;
    be_i         = 4'hF;
    wdata_i      = $urandom;
    tgt_gnt_i    = g;
    tgt_rvalid_i = rv;
    tgt_err_i    = '0;
    for (int k = 0; k < 5; k++) tgt_rdata_i[k] = {8{4'(k + 1)}};
    tgt_rdata_i[2] = 32'hDEAD_BEEF;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [12];
    edges = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_4FFC, 32'h0000_5000,
              32'h0000_8FFC, 32'h0000_9000, 32'h0000_9FFC, 32'h0000_A000,
              32'h0000_FFFC, 32'h0001_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    case ($urandom_range(0, 7))
      0:       return 32'($urandom_range(0, 32'hFFF));
      1:       return 32'h1000 + 32'($urandom_range(0, 32'h3FFF));
      2:       return 32'h5000 + 32'($urandom_range(0, 32'h3FFF));
      3:       return 32'h9000 + 32'($urandom_range(0, 32'hFFF));
      4:       return 32'hA000 + 32'($urandom_range(0, 32'h5FFF));
      5:       return 32'($urandom_range(32'h1_0000, 32'hFFFF_FFFF));
      6:       return edges[$urandom_range(0, 11)];
      default: return $urandom;
    endcase
  endfunction

  // Random targets: the current target answers in order; idle targets emit stray rvalids.
  task automatic rand_cycle();
    int h;
    @(posedge clk_i);
    #1;
    req_i   = ($urandom_range(0, 9) < 7) && !drain;
    addr_i  = rand_addr();
    we_i    = 1'($urandom);
    be_i    = 4'($urandom);
    wdata_i = $urandom;
    for (int k = 0; k < 5; k++) begin
      tgt_gnt_i[k]    = ($urandom_range(0, 3) != 0);
      tgt_rdata_i[k]  = $urandom;
      tgt_err_i[k]    = ($urandom_range(0, 7) == 0);
      tgt_rvalid_i[k] = ($urandom_range(0, 4) == 0);
    end
    h = (outs.size() > 0) ? outs[0] : 5;
    if (h < 5) tgt_rvalid_i[h] = drain || ($urandom_range(0, 1) == 1);
  endtask

  logic [31:0] b_addr [6];
  logic [4:0]  b_req  [6];

  initial begin
    rst_i        = 1'b1;
    req_i        = 1'b0;
    addr_i       = '0;
    we_i         = 1'b0;
    be_i         = '0;
    wdata_i      = '0;
    tgt_gnt_i    = '0;
    tgt_rvalid_i = '0;
    tgt_rdata_i  = '0;
    tgt_err_i    = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // dmem read with a response two cycles after the grant
    drive(1, 32'h0000_5004, 5'b00100, 5'b00000);
    @(negedge clk_i);
    chk("dmem_gnt", 32'(gnt_o), 1);
    chk("dmem_tgt_req", 32'(tgt_req_o), 32'(5'b00100));
    drive(0, 0, 5'b00000, 5'b00000);
    @(negedge clk_i);
    chk("dmem_wait_rvalid", 32'(rvalid_o), 0);
    drive(0, 0, 5'b00000, 5'b00100);
    @(negedge clk_i);
    chk("dmem_rvalid", 32'(rvalid_o), 1);
    chk("dmem_rdata", rdata_o, 32'hDEAD_BEEF);
    // cnt back at 0: a different target is granted at once, stray dmem rvalid ignored
    drive(1, 32'h0000_1000, 5'b00010, 5'b00100);
    @(negedge clk_i);
    chk("after_dmem_gnt", 32'(gnt_o), 1);
    chk("stray_ignored", 32'(rvalid_o), 0);
    drive(0, 0, 5'b00000, 5'b00010);
    @(negedge clk_i);
    chk("imem_rdata", rdata_o, 32'h2222_2222);

    // decode boundaries
    b_addr = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_8FFC, 32'h0000_9FFC,
               32'h0001_0000, 32'hFFFF_FFFF};
    b_req  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000};
    for (int i = 0; i < 6; i++) begin
      drive(1, b_addr[i], 5'b11111, 5'b00000);
      @(negedge clk_i);
      chk($sformatf("bound_req_%h", b_addr[i]), 32'(tgt_req_o), 32'(b_req[i]));
      drive(0, 0, 5'b00000, 5'b11111);
      @(negedge clk_i);
      chk($sformatf("bound_rsp_%h", b_addr[i]), 32'(rvalid_o), 1);
    end

    // unmapped access answered by the error responder
    drive(1, 32'h0000_A000, 5'b00000, 5'b00000);
    @(negedge clk_i);
    chk("unmapped_gnt", 32'(gnt_o), 1);
    chk("unmapped_tgt_req", 32'(tgt_req_o), 0);
    drive(0, 0, 5'b00000, 5'b11111);
    @(negedge clk_i);
    chk("unmapped_rvalid", 32'(rvalid_o), 1);
    chk("unmapped_err", 32'(err_o), 1);
    chk("unmapped_rdata", rdata_o, 0);
    drive(0, 0, 5'b00000, 5'b00000);
    @(negedge clk_i);
    chk("unmapped_single", 32'(rvalid_o), 0);

    // target switch and stall at the outstanding limit
    drive(1, 32'h0000_1000, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sw_imem0_gnt", 32'(gnt_o), 1);
    drive(1, 32'h0000_1004, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sw_imem1_gnt", 32'(gnt_o), 1);
    drive(1, 32'h0000_1008, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sw_imem2_stall", 32'(gnt_o), 0);
    chk("sw_imem2_noreq", 32'(tgt_req_o), 0);
    drive(1, 32'h0000_5000, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sw_dmem_wait0", 32'(gnt_o), 0);
    drive(1, 32'h0000_5000, 5'b11111, 5'b00010);
    @(negedge clk_i);
    chk("sw_dmem_wait1", 32'(gnt_o), 0);
    chk("sw_imem_rsp0", 32'(rvalid_o), 1);
    drive(1, 32'h0000_5000, 5'b11111, 5'b00010);
    @(negedge clk_i);
    chk("sw_dmem_gnt", 32'(gnt_o), 1);
    chk("sw_dmem_req", 32'(tgt_req_o), 32'(5'b00100));
    chk("sw_imem_rsp1", 32'(rvalid_o), 1);
    drive(0, 0, 5'b00000, 5'b00100);
    @(negedge clk_i);
    chk("sw_dmem_rdata", rdata_o, 32'hDEAD_BEEF);

    // grant and response together at cnt=1 keep cnt at 1
    drive(1, 32'h0000_1000, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sim_gnt0", 32'(gnt_o), 1);
    drive(1, 32'h0000_1004, 5'b11111, 5'b00010);
    @(negedge clk_i);
    chk("sim_gnt1", 32'(gnt_o), 1);
    chk("sim_rsp", 32'(rvalid_o), 1);
    drive(1, 32'h0000_1008, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sim_cnt_was_1", 32'(gnt_o), 1);
    drive(1, 32'h0000_100C, 5'b11111, 5'b00000);
    @(negedge clk_i);
    chk("sim_cnt_now_max", 32'(gnt_o), 0);
    drive(0, 0, 5'b00000, 5'b00010);
    drive(0, 0, 5'b00000, 5'b00010);

    // reset mid-transaction with two dmem requests outstanding
    drive(1, 32'h0000_5000, 5'b11111, 5'b00000);
    drive(1, 32'h0000_5004, 5'b11111, 5'b00000);
    drive(1, 32'h0000_5008, 5'b11111, 5'b00100);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_async_gnt", 32'(gnt_o), 0);
    chk("rst_async_req", 32'(tgt_req_o), 0);
    chk("rst_async_rvalid", 32'(rvalid_o), 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_late_rvalid", 32'(rvalid_o), 0);
    drive(0, 0, 5'b00000, 5'b00100);
    @(negedge clk_i);
    chk("post_rst_late_rvalid2", 32'(rvalid_o), 0);
    drive(1, 32'h0000_1000, 5'b00010, 5'b00100);
    @(negedge clk_i);
    chk("post_rst_gnt", 32'(gnt_o), 1);
    chk("post_rst_rvalid", 32'(rvalid_o), 0);
    drive(0, 0, 5'b00000, 5'b00010);

    // random traffic
    repeat (3000) rand_cycle();
    drain = 1'b1;
    repeat (30) rand_cycle();
    @(negedge clk_i);
    #2;
    chk("drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zeroheti_bus_demux.md
ZEROHETI_BUS_DEMUX -- requirements
Module: zeroheti_bus_demux

Interface
REQ-001 SHALL have parameter AddrMap, default zeroheti_pkg::AddrMap, the system address map (dbg, imem, dmem, clic, ext rules).
REQ-002 SHALL have parameter MaxOutstanding, default 2, the maximum number of accepted but unanswered requests (range 1..7).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have initiator-side ports, with indices 0..4 = dbg, imem, dmem, clic, ext:
- req_i, input, 1 bit: request.
- gnt_o, output, 1 bit: grant.
- addr_i, input, 32 bits: address.
- we_i, input, 1 bit: write enable.
- be_i, input, 4 bits: byte enables.
- wdata_i, input, 32 bits: write data.
REQ-006 SHALL have initiator-side response ports:
- rvalid_o, output, 1 bit: response valid.
- rdata_o, output, 32 bits: read data.
- err_o, output, 1 bit: error.
REQ-007 SHALL have target-side ports:
- tgt_req_o, output, 5 bits: per-target request.
- tgt_gnt_i, input, 5 bits: per-target grant.
- tgt_addr_o, output, 32 bits; tgt_we_o, output, 1 bit; tgt_be_o, output, 4 bits; tgt_wdata_o, output, 32 bits: broadcast request fields.
REQ-008 SHALL have target-side response ports:
- tgt_rvalid_i, input, 5 bits: per-target response valid.
- tgt_rdata_i, input, 5x32 bits: per-target read data.
- tgt_err_i, input, 5 bits: per-target error.

Function
REQ-009 SHALL decode rule k as a hit when base_k <= addr_i < last_k; the ext rule SHALL also hit on addr_i == 32'hFFFF_FFFF.
REQ-010 SHALL treat an address hitting no rule (e.g. 0x0000_A000..0x0000_FFFF) as unmapped, routed to an internal error responder (target 5).
REQ-011 SHALL drive tgt_addr_o/we/be/wdata combinationally equal to the initiator fields at all times.
REQ-012 SHALL assert tgt_req_o[k] only when req_i=1, decode=k, and the request is admissible.
- Admissible means: cnt < MaxOutstanding and (cnt==0 or cur_tgt==decode).
REQ-013 SHALL assert gnt_o as follows:
- Mapped target k: gnt_o = tgt_req_o[k] & tgt_gnt_i[k].
- Unmapped: gnt_o = req_i & admissible, with no tgt_req_o asserted.
REQ-014 SHALL keep cur_tgt (3 bits) and cnt (0..MaxOutstanding); on each grant cur_tgt SHALL load the decoded index.
REQ-015 SHALL update cnt as follows:
- +1 on a grant.
- -1 on a delivered response.
- Unchanged when both occur in the same cycle.
REQ-016 SHALL, for cur_tgt<5 and cnt>0, set rvalid_o = tgt_rvalid_i[cur_tgt], rdata_o = tgt_rdata_i[cur_tgt], err_o = tgt_err_i[cur_tgt].
REQ-017 SHALL ignore tgt_rvalid_i from any target other than cur_tgt, or when cnt==0.
REQ-018 SHALL make the error responder answer each unmapped request in order, one per cycle, the first response in the cycle after its grant.
- Each response: rvalid_o=1, err_o=1, rdata_o=0.
REQ-019 SHALL hold rdata_o=0 and err_o=0 whenever rvalid_o=0.
REQ-020 SHALL, when a request must wait because its target differs from cur_tgt, hold gnt_o=0 until cnt reaches 0; the request is admissible in the same cycle the last response drains.

Reset
REQ-021 SHALL, while rst_i=1 (asynchronously), force cnt=0, cur_tgt=0, and the error pending state cleared.
REQ-022 SHALL drive these outputs to 0 during reset: gnt_o, rvalid_o, err_o, rdata_o, tgt_req_o.
REQ-023 SHALL discard responses to transactions in flight when reset is asserted; after reset is released, tgt_rvalid_i SHALL be ignored until a new grant occurs.

Verification
REQ-024 SHALL cover a dmem read: addr 0x0000_5004, gnt after 0 wait states, rvalid with 0xDEAD_BEEF 2 cycles later -> gnt_o=1, tgt_req_o=5'b00100, rvalid_o=1, rdata_o=0xDEAD_BEEF, cnt ends at 0.
REQ-025 SHALL cover boundaries: addr 0x0000_0FFC, 0x0000_1000, 0x0000_8FFC, 0x0001_0000, 0xFFFF_FFFF -> tgt_req_o = dbg, imem, dmem, ext, ext respectively.
REQ-026 SHALL cover an unmapped access: addr 0x0000_A000 -> gnt_o=1 in the same cycle, then the next cycle rvalid_o=1, err_o=1, rdata_o=0, and no tgt_req_o asserted.
REQ-027 SHALL cover a target switch: two imem reads granted (cnt=2), then a dmem request -> gnt_o=0 until the second imem rvalid, dmem granted in that cycle, and a third imem request stalls at cnt==MaxOutstanding.
REQ-028 SHALL cover a simultaneous event: a grant and a response in the same cycle at cnt=1 -> cnt stays 1.
REQ-029 SHALL cover reset mid-transaction: rst_i pulsed with cnt=2, then a late tgt_rvalid_i[2] -> rvalid_o stays 0.
